des_key_schedule: RTL



---
 rtl/des_pkg.sv | 47 ++++
 rtl/des_key_schedule_if.sv | 26 ++
 rtl/des_pc2.sv | 13 +
 rtl/des_key_schedule.sv | 99 +++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, rotation schedule and key-schedule state type.
// The tables hold 1-based DES bit positions so they read like the standard.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam byte unsigned PC1 [56] = '{
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam byte unsigned PC2 [48] = '{
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  // Left-rotation amount before round 1..16, stored 0-based.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle of the DES key schedule.
// slave is the schedule's view, master the driver/consumer side.
interface des_key_schedule_if;
  import des_pkg::*;

  logic                key_valid;
  logic                key_ready;
  logic [KEY_W-1:0]    key;
  logic                decrypt;
  logic                sk_valid;
  logic                sk_ready;
  logic [SUBKEY_W-1:0] subkey;
  logic [3:0]          sk_round;
  logic                sk_last;

  modport slave (
    input  key_valid, key, decrypt, sk_ready,
    output key_ready, sk_valid, subkey, sk_round, sk_last
  );

  modport master (
    output key_valid, key, decrypt, sk_ready,
    input  key_ready, sk_valid, subkey, sk_round, sk_last
  );

endinterface

// File: rtl/des_pc2.sv
// DES permuted choice 2: pure wiring from the 56-bit {C,D} pair to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0]   cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign subkey_o[SUBKEY_W-1-i] = cd_i[2*CD_W - int'(PC2[i])];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one 28-bit C/D register pair rotated per handshake,
// emitting K1..K16 (encrypt) or K16..K1 (decrypt) through a combinational PC-2.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input logic               clk,
  input logic               rst_n,
  des_key_schedule_if.slave kif
);

  state_e          state_q, state_d;
  logic [CD_W-1:0] c_half_q, c_half_d;
  logic [CD_W-1:0] d_half_q, d_half_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            key_ready_q, key_ready_d;

  logic [2*CD_W-1:0] cd0;
  logic [CD_W-1:0]   c0, d0;
  logic [1:0]        enc_shift, dec_shift;

  for (genvar i = 0; i < 2*CD_W; i++) begin : g_pc1
    assign cd0[2*CD_W-1-i] = kif.key[KEY_W - int'(PC1[i])];
  end

  assign c0 = cd0[2*CD_W-1:CD_W];
  assign d0 = cd0[CD_W-1:0];

  // Encrypt moves forward to C(cnt+2); decrypt undoes the rotation that produced C(16-cnt).
  assign enc_shift = SHIFT[cnt_q + 4'd1];
  assign dec_shift = SHIFT[4'd15 - cnt_q];

  always_comb begin
    state_d  = state_q;
    c_half_d = c_half_q;
    d_half_d = d_half_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    unique case (state_q)
      StIdle: begin
        if (kif.key_valid && key_ready_q) begin
          state_d = StRun;
          cnt_d   = '0;
          mode_d  = kif.decrypt;
          // Total rotation over 16 rounds is 28, so C0/D0 already equal C16/D16.
          c_half_d = kif.decrypt ? c0 : rotl(c0, 2'd1);
          d_half_d = kif.decrypt ? d0 : rotl(d0, 2'd1);
        end
      end
      StRun: begin
        if (kif.sk_ready) begin
          if (cnt_q == 4'd15) begin
            state_d = StIdle;
          end else begin
            cnt_d    = cnt_q + 4'd1;
            c_half_d = mode_q ? rotr(c_half_q, dec_shift) : rotl(c_half_q, enc_shift);
            d_half_d = mode_q ? rotr(d_half_q, dec_shift) : rotl(d_half_q, enc_shift);
          end
        end
      end
    endcase
    key_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      c_half_q    <= '0;
      d_half_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_half_q    <= c_half_d;
      d_half_q    <= d_half_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign kif.key_ready = key_ready_q;
  assign kif.sk_valid  = (state_q == StRun);
  assign kif.sk_round  = mode_q ? (4'd15 - cnt_q) : cnt_q;
  assign kif.sk_last   = (state_q == StRun) && (cnt_q == 4'd15);

  des_pc2 u_pc2 (
    .cd_i     ({c_half_q, d_half_q}),
    .subkey_o (kif.subkey)
  );

  a_round_in_range: assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == StRun) |-> (32'(cnt_q) < NUM_ROUNDS)
  );

endmodule
